// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//
// Turns single-cycle trigger pulses into fixed-width level pulses. Each
// trigger gives WIDTH cycles of out=1, followed by at least GAP cycles of
// out=0. Triggers that arrive while a pulse or its gap is in progress are
// counted. They are replayed in order, up to MAXPEND of them. Any further
// trigger is dropped and flagged on overflow.
//
// Optional feature, controlled by the macro PULSE_STRETCHER_RETRIGGER_EN:
//   defined   : retrigger mode. A trigger during HIGH restarts the width.
//               A trigger during GAP goes straight back to HIGH. There is
//               no queue, so pending and overflow stay 0.
//   undefined : queueing mode, as described above (this is the default).
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high
//   in       in   trigger; every cycle sampled high is one trigger
//   out      out  stretched pulse (registered)
//   busy     out  high whenever the FSM is not IDLE (registered)
//   pending  out  number of queued triggers (registered)
//   overflow out  one-cycle strobe: a trigger was dropped (registered)
//
// Handshake: none. Every cycle in which in=1 is sampled is one trigger
// event. There is no back-pressure; a trigger that cannot be queued is
// dropped and reported on overflow.
module pulse_stretcher #(
  parameter int WIDTH   = 4,
  parameter int GAP     = 1,
  parameter int MAXPEND = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in,
  output logic                         out,
  output logic                         busy,
  output logic [$clog2(MAXPEND+1)-1:0] pending,
  output logic                         overflow
);

  localparam int CNT_MAX = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(MAXPEND + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            out_q, out_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;

`ifndef PULSE_STRETCHER_RETRIGGER_EN
  logic            end_seq;   // last cycle of the busy sequence
  logic            take;      // this cycle's trigger starts a pulse
  logic            pop;       // a queued trigger starts a pulse
  logic            arrive;    // this cycle's trigger must be queued
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    pend_d = '0;
    case (state_q)
      S_IDLE: begin
        if (in) begin
          state_d = S_HIGH;
          cnt_d   = CW'(WIDTH - 1);
        end
      end
      S_HIGH: begin
        if (in) begin
          cnt_d = CW'(WIDTH - 1);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP > 0) begin
          state_d = S_GAP;
          cnt_d   = CW'(GAP - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (in) begin
          state_d = S_HIGH;
          cnt_d   = CW'(WIDTH - 1);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`else
    end_seq = 1'b0;
    take    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in) begin
          state_d = S_HIGH;
          cnt_d   = CW'(WIDTH - 1);
          take    = 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP > 0) begin
          state_d = S_GAP;
          cnt_d   = CW'(GAP - 1);
        end else begin
          // With no gap, the last high cycle is also the end of the sequence.
          end_seq = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             end_seq = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // The queue takes priority over a fresh trigger, so pulses replay in order.
    if (end_seq) begin
      if (pend_q != '0) begin
        state_d = S_HIGH;
        cnt_d   = CW'(WIDTH - 1);
        pop     = 1'b1;
      end else if (in) begin
        state_d = S_HIGH;
        cnt_d   = CW'(WIDTH - 1);
        take    = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end

    arrive = in && !take;
    if (pop && arrive) begin
      pend_d = pend_q;  // one consumed, one queued
    end else if (pop) begin
      pend_d = pend_q - 1'b1;
    end else if (arrive) begin
      if (pend_q == PW'(MAXPEND)) ovf_d  = 1'b1;
      else                        pend_d = pend_q + 1'b1;
    end
`endif
    out_d  = (state_d == S_HIGH);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher
//
// Bench for pulse_stretcher with its default parameters. A reference model
// tracks how many busy cycles remain. out is high while more than GAP busy
// cycles remain. The model is advanced once per driven cycle, and its result
// is pushed to a queue. The result is popped and compared just after the
// next rising edge.
module tb_pulse_stretcher;

  localparam int WIDTH   = 4;
  localparam int GAP     = 1;
  localparam int MAXPEND = 3;
  localparam int PW      = $clog2(MAXPEND + 1);
  localparam int EW      = PW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in  = 1'b0;
  logic          out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .WIDTH   (WIDTH),
    .GAP     (GAP),
    .MAXPEND (MAXPEND)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .out      (out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // model state: busy cycles remaining (0 = idle), queued triggers
  int   m_left = 0;
  int   m_pend = 0;
  logic m_ovf  = 1'b0;

  // observation counters for directed checks
  int   rises = 0;
  int   ovfs  = 0;
  logic prev_out = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic in_v, input logic rst_v);
    m_ovf = 1'b0;
    if (rst_v) begin
      m_left = 0;
      m_pend = 0;
    end else begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
      if (in_v)            m_left = WIDTH + GAP;
      else if (m_left > 0) m_left = m_left - 1;
`else
      if (m_left == 0) begin
        if (in_v) m_left = WIDTH + GAP;
      end else if (m_left == 1) begin
        if (m_pend > 0) begin
          m_left = WIDTH + GAP;
          if (!in_v) m_pend = m_pend - 1;
        end else if (in_v) begin
          m_left = WIDTH + GAP;
        end else begin
          m_left = 0;
        end
      end else begin
        m_left = m_left - 1;
        if (in_v) begin
          if (m_pend == MAXPEND) m_ovf = 1'b1;
          else                   m_pend = m_pend + 1;
        end
      end
`endif
    end
  endtask

  // Drive one cycle, predict, then compare after the edge.
  task automatic step(input logic in_v, input logic rst_v);
    logic [EW-1:0] e;
    @(negedge clk);
    in  = in_v;
    rst = rst_v;
    model_step(in_v, rst_v);
    exp_q.push_back({(m_left > GAP), (m_left > 0), PW'(m_pend), m_ovf});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("out",      32'(out),      32'(e[EW-1]));
    check_eq("busy",     32'(busy),     32'(e[EW-2]));
    check_eq("pending",  32'(pending),  32'(e[PW:1]));
    check_eq("overflow", 32'(overflow), 32'(e[0]));
    if (out && !prev_out) rises++;
    prev_out = out;
    if (overflow) ovfs++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic clear_obs();
    rises = 0;
    ovfs  = 0;
  endtask

  initial begin
    // reset
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle(2);

    // single trigger
    clear_obs();
    step(1'b1, 1'b0);
    idle(10);
    check_eq("single_rises", rises, 1);
    check_eq("single_ovf", ovfs, 0);

    // two triggers two cycles apart
    clear_obs();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle(15);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check_eq("pair_rises", rises, 1);
`else
    check_eq("pair_rises", rises, 2);
`endif

    // in held for five cycles: the queue fills and one trigger is dropped
    clear_obs();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    idle(30);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check_eq("hold5_rises", rises, 1);
    check_eq("hold5_ovf", ovfs, 0);
`else
    check_eq("hold5_rises", rises, 4);
    check_eq("hold5_ovf", ovfs, 1);
`endif

    // reset in the middle of a pulse with triggers queued
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    clear_obs();
    idle(12);
    check_eq("post_reset_rises", rises, 0);

    // trigger on the last gap cycle while one trigger is queued
    clear_obs();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle(20);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check_eq("gap_end_rises", rises, 1);
`else
    check_eq("gap_end_rises", rises, 3);
`endif

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
    end
    idle(30);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle trigger pulses, such as those from the single-pulser edge detector, back into fixed-width level pulses on `out`.
- Each trigger produces exactly one high window of `WIDTH` cycles, followed by a guaranteed low gap of `GAP` cycles.
- Triggers arriving while a pulse is in progress are counted and replayed in order, up to a bounded depth.
- Used to drive LEDs, enables, or strobes that must be wide enough to see or meet a minimum width.

Parameters:
- WIDTH, 4, cycles `out` is held high per trigger; must be ≥1.
- GAP, 1, minimum low cycles between consecutive stretched pulses; may be 0.
- MAXPEND, 3, maximum triggers queued while busy; must be ≥1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- in  input  1  trigger; every cycle sampled high counts as one trigger.
- out  output  1  stretched pulse, registered.
- busy  output  1  high in HIGH or GAP state.
- pending  output  $clog2(MAXPEND+1)  number of queued triggers.
- overflow  output  1  one-cycle strobe: a trigger was dropped.

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs are registered.
  - out=0, busy=0, pending=0, overflow=0, state=IDLE.
  - Reset asserted mid-operation aborts the current pulse and clears the queue. `out` is 0 the cycle after the reset edge.
- States: IDLE, HIGH, GAP.
  - Down-counter `cnt` has width $clog2(max(WIDTH,GAP)+1).
- IDLE:
  - in=1 → HIGH, cnt=WIDTH-1, out=1 from the next cycle. Latency is 1 clock from sampling `in` to `out` rising.
  - `pending` is unchanged.
- HIGH:
  - out=1.
  - cnt>0 → decrement.
  - cnt==0 and GAP>0 → GAP, cnt=GAP-1.
  - cnt==0 and GAP==0 → behave as the end of GAP (below), without a low cycle.
- GAP:
  - out=0.
  - cnt>0 → decrement.
  - cnt==0 and pending>0 → HIGH, cnt=WIDTH-1, pending-1.
  - cnt==0 and pending==0 and in=1 → HIGH, pending unchanged.
  - otherwise → IDLE.
- Queueing: in=1 while busy and not consumed by a transition → pending+1.
- Simultaneous events:
  - A trigger arriving in the same cycle a queued trigger is consumed leaves `pending` unchanged.
  - A trigger at GAP end with pending==0 starts HIGH directly.
- Full: pending==MAXPEND and a trigger arrives that is not consumed that cycle → trigger dropped, pending stays MAXPEND, overflow=1 for exactly one cycle.
- busy=1 whenever state≠IDLE.
- With GAP=0, back-to-back pulses merge: `out` stays high for WIDTH×(number of triggers) cycles.
- Counters never wrap; `pending` saturates at MAXPEND.

Optional Feature:
- Macro: PULSE_STRETCHER_RETRIGGER_EN.
- When defined (retrigger mode):
  - in=1 during HIGH reloads cnt=WIDTH-1, extending the current pulse.
  - in=1 during GAP immediately returns to HIGH.
  - No queue: `pending` is tied to 0 and `overflow` is tied to 0.
- When undefined: queueing behaviour as above.

Test Plan (defaults WIDTH=4, GAP=1, MAXPEND=3):
- Reset 2 cycles, then in=1 for 1 cycle at cycle 5 → out=1 cycles 6–9, out=0 at cycle 10 with busy=1 (gap), busy=0 at cycle 11; overflow never asserted.
- Triggers at cycles 5 and 7 → out high 6–9, low 10, high 11–14; pending reads 1 during cycles 8–10 and 0 from cycle 11.
- in held high cycles 5–9 (5 triggers) → first starts immediately, pending reaches 3, fifth dropped with overflow=1 for exactly one cycle; exactly 4 output pulses, each 4 high / 1 low.
- rst=1 at cycle 8 while HIGH with pending=2 → from cycle 9 out=0, busy=0, pending=0; no further pulses with in=0.
- pending=1 and in=1 in the last GAP cycle → next HIGH starts, pending stays 1; two more pulses follow in total.
- PULSE_STRETCHER_RETRIGGER_EN defined, triggers at cycles 5 and 7 → out high continuously cycles 6–11 (6 cycles), then low; pending=0 and overflow=0 throughout.
